mul_scheduler: RTL
==================

MUL_SCHEDULER -- requirements
Module: mul_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports reqValid0 / reqValid1, input, 1 each, requester 0/1 has an operand pending.
REQ-005 The block SHALL have ports reqData0 / reqData1, input, WIDTH each, requester 0/1 operand.
REQ-006 The block SHALL have ports reqReady0 / reqReady1, output, 1 each, operand of requester 0/1 accepted this cycle.
REQ-007 The block SHALL have port respValid, output, 1, result available.
REQ-008 The block SHALL have port respData, output, WIDTH, (operand*10) mod 2^WIDTH.
REQ-009 The block SHALL have port respId, output, 1, index of the requester that owns respData.
REQ-010 The block SHALL have port respReady, input, 1, consumer accepts the result.

Function
REQ-011 The block SHALL share one multiply-by-10 datapath between two requesters, with at most one operation in flight.
REQ-012 The FSM SHALL have states IDLE, ADD8, ADD2 and DONE.
REQ-013 In IDLE, the block SHALL assert exactly one reqReadyN, combinationally, when at least one reqValid is high; otherwise both reqReady SHALL be low.
REQ-014 Arbitration SHALL be round-robin: if both requesters are valid, the grant goes to the requester named by the 1-bit pointer prio.
REQ-015 If only one requester is valid, the grant SHALL go to that requester.
REQ-016 On every accept, prio SHALL be set to the non-granted index.
REQ-017 An accept SHALL occur on a rising edge with reqValidN=1 and reqReadyN=1; the block SHALL capture the operand and grant index, and the FSM SHALL move from IDLE to ADD8.
REQ-018 In ADD8, the accumulator SHALL load operand<<3, and the FSM SHALL move to ADD2.
REQ-019 In ADD2, the accumulator SHALL add operand<<1, and the FSM SHALL move to DONE.
REQ-020 All arithmetic SHALL be truncated to WIDTH bits; wrap-around is not an error.
REQ-021 In DONE, respValid SHALL be 1, and respData and respId SHALL be registered and stable until the handshake completes.
REQ-022 respValid SHALL rise exactly 3 rising edges after the accept edge.
REQ-023 On a rising edge with respValid=1 and respReady=1, the FSM SHALL return to IDLE and respValid SHALL fall.
REQ-024 A new accept SHALL happen no earlier than the following edge; there is no bypass, giving a minimum 4-cycle throughput per operation.
REQ-025 While the FSM is not in IDLE, both reqReady SHALL be 0 regardless of reqValid.
REQ-026 If respReady is held 0, the block SHALL stay in DONE indefinitely with outputs unchanged.
REQ-027 A requester dropping reqValid after its accept SHALL have no effect on the operation in flight.
REQ-028 A reqValid change in a non-IDLE state SHALL NOT move prio.

Reset
REQ-029 When rst_n=0, the block SHALL immediately force: state=IDLE, prio=0, respValid=0, respData=0, respId=0 and the accumulator to 0.
REQ-030 Reset asserted mid-operation SHALL discard the operation in flight, and no response SHALL be produced for it.
REQ-031 After rst_n deasserts, the first grant on simultaneous requests SHALL go to requester 0.

Configuration
REQ-032 When macro MUL_SCHED_OVF_EN is defined, the block SHALL add an output respOvf, 1 bit, registered alongside respData; respOvf SHALL be 1 when operand*10 >= 2^WIDTH, and SHALL reset to 0.
REQ-033 When MUL_SCHED_OVF_EN is undefined, port respOvf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Single request reqData0=0x0000_0111 accepted at edge k with respReady=1 -> respValid at edge k+3, respData=0x0000_0AAA, respId=0.
REQ-035 Both valid after reset, reqData0=0x1, reqData1=0x2, respReady=1 -> responses 0x0000_000A (id 0) then 0x0000_0014 (id 1); reqReady1 low during the first operation.
REQ-036 Operand 0x1999_9999 -> respData=0xFFFF_FFFA; operand 0x1999_999A -> respData=0x0000_0004, with respOvf=1 when MUL_SCHED_OVF_EN is defined.
REQ-037 respReady held 0 for 5 cycles in DONE -> respValid, respData and respId constant, and both reqReady low throughout.
REQ-038 rst_n pulsed low in ADD2 -> respValid stays 0, with no response for that operand; the next simultaneous request is granted to requester 0.

Source files
------------

// File: rtl/mul_scheduler.sv
// Purpose : two-requester round-robin front end for one shared multiply-by-10 datapath (x*8 + x*2).
// Latency : accept on edge k; respValid is first sampled high on edge k+3; next accept no earlier than k+4.
// Backpres: one operation in flight; both reqReady low outside IDLE; DONE holds until respReady.
// Optional: define MUL_SCHED_OVF_EN to add respOvf, flagging operand*10 >= 2^WIDTH.
module mul_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reqValid0,
  input  logic [WIDTH-1:0] reqData0,
  output logic             reqReady0,
  input  logic             reqValid1,
  input  logic [WIDTH-1:0] reqData1,
  output logic             reqReady1,
  output logic             respValid,
  output logic [WIDTH-1:0] respData,
  output logic             respId,
  input  logic             respReady
`ifdef MUL_SCHED_OVF_EN
  ,
  output logic             respOvf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD8 = 2'd1;
  localparam logic [1:0] ADD2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             prio_q,  prio_d;
  logic [WIDTH-1:0] op_q,    op_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic             id_q,    id_d;
  logic             idle;
  logic             grant1;
  logic             accept;

  // Grants are only offered from IDLE. Requester 1 wins when it is the sole
  // requester, or when both ask and the round-robin pointer names it.
  assign idle      = (state_q == IDLE);
  assign grant1    = reqValid1 & (~reqValid0 | prio_q);
  assign reqReady0 = idle & reqValid0 & ~grant1;
  assign reqReady1 = idle & grant1;
  assign accept    = reqReady0 | reqReady1;

  // The accumulator doubles as the result register, so respData is stable
  // for the whole DONE state without a separate output flop.
  assign respValid = (state_q == DONE);
  assign respData  = acc_q;
  assign respId    = id_q;

  // Next-state: capture on accept, x*8 then +x*2, then hold until consumed.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    op_d    = op_q;
    acc_d   = acc_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = grant1 ? reqData1 : reqData0;
          id_d    = grant1;
          prio_d  = ~grant1;
          state_d = ADD8;
        end
      end
      ADD8: begin
        acc_d   = op_q << 3;
        state_d = ADD2;
      end
      ADD2: begin
        acc_d   = acc_q + (op_q << 1);
        state_d = DONE;
      end
      DONE: begin
        if (respReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any operation in flight and restarts
  // arbitration with requester 0 favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      acc_q   <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      id_q    <= id_d;
    end
  end

`ifdef MUL_SCHED_OVF_EN
  logic [WIDTH+3:0] prod_x;
  logic             ovf_q, ovf_d;

  // Full-precision product; any bit above WIDTH means the result wrapped.
  assign prod_x  = ({4'b0000, op_q} << 3) + ({4'b0000, op_q} << 1);
  assign respOvf = ovf_q;

  // Overflow flag is latched with the final add so it lines up with respData.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == ADD2) begin
      ovf_d = |prod_x[WIDTH+3:WIDTH];
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

endmodule
